// File: rtl/dff_arbiter.sv
// -----------------------------------------------------------------------------
// dff_arbiter
//   Two-requester arbiter in front of one shared N-bit register. Each edge
//   with ENABLE=1 grants at most one requester, whose data is written into Q.
//
//   Arbitration:
//     - Round-robin between REQ0 and REQ1 using a 1-bit priority pointer (PRI).
//     - A granted requester that also holds its LOCK input keeps ownership for
//       up to MAX_BURST consecutive grants. After that it is forced out for one
//       arbitration round.
//
// Ports
//   CLOCK          rising-edge clock
//   RESET          asynchronous, active-low reset
//   ENABLE         global advance; 0 freezes all state and zeroes the grants
//   REQ0/REQ1      write requests
//   LOCK0/LOCK1    ask to keep ownership after the grant
//   D0/D1          write data, N bits each
//   Q              shared register contents
//   GNT0/GNT1      one-cycle registered grant pulses (cycle after the write)
//   OWNER          index of the requester whose data is in Q
//   LOCKED         FSM is in LOCK0 or LOCK1
// -----------------------------------------------------------------------------
module dff_arbiter #(
  parameter int N         = 16,
  parameter int MAX_BURST = 4   // 1..7, must fit the 3-bit burst counter
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         ENABLE,
  input  logic         REQ0,
  input  logic         REQ1,
  input  logic         LOCK0,
  input  logic         LOCK1,
  input  logic [N-1:0] D0,
  input  logic [N-1:0] D1,
  output logic [N-1:0] Q,
  output logic         GNT0,
  output logic         GNT1,
  output logic         OWNER,
  output logic         LOCKED
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  localparam logic [2:0] BURST_MAX = 3'(MAX_BURST);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t         state_q, state_d;
  logic           pri_q,   pri_d;
  logic [2:0]     cnt_q,   cnt_d;
  logic [N-1:0]   q_q,     q_d;
  logic           owner_q, owner_d;
  logic           gnt0_q,  gnt0_d;
  logic           gnt1_q,  gnt1_d;

  // ---------------------------------------------------------------------------
  // Arbitration scratch
  // ---------------------------------------------------------------------------
  logic [1:0]     req_m;     // requests after excluding an exhausted owner
  logic           pri_eff;   // pointer used for this edge's arbitration
  logic           arb;       // this edge runs a fresh (IDLE-style) arbitration
  logic           cur;       // owner index while locked
  logic           lock_cur;  // LOCK input of the current owner
  logic           g;         // winner of a fresh arbitration
  logic           lock_g;    // LOCK input of that winner

  always_comb begin
    state_d  = state_q;
    pri_d    = pri_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    owner_d  = owner_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;

    req_m    = {REQ1, REQ0};
    pri_eff  = pri_q;
    arb      = 1'b0;
    cur      = (state_q == ST_LOCK1);
    lock_cur = cur ? LOCK1 : LOCK0;
    g        = 1'b0;
    lock_g   = 1'b0;

    if (ENABLE) begin
      if (state_q == ST_IDLE) begin
        arb = 1'b1;
      end else begin
        if (cnt_q >= BURST_MAX) begin
          // Burst exhausted: the owner sits out this round so the other side
          // gets a chance even if the owner is still requesting.
          req_m[cur] = 1'b0;
          arb        = 1'b1;
        end else if (req_m[cur] && lock_cur) begin
          // Continue the locked burst; the other request is ignored.
          q_d     = cur ? D1 : D0;
          owner_d = cur;
          gnt0_d  = ~cur;
          gnt1_d  = cur;
          cnt_d   = cnt_q + 3'd1;
        end else begin
          arb = 1'b1;
        end

        // Leaving a lock hands priority to the other side before this edge's
        // arbitration, so a waiting requester wins a tie immediately.
        if (arb) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
          pri_d   = ~cur;
          pri_eff = ~cur;
        end
      end

      if (arb && (req_m != 2'b00)) begin
        g       = (&req_m) ? pri_eff : req_m[1];
        lock_g  = g ? LOCK1 : LOCK0;
        q_d     = g ? D1 : D0;
        owner_d = g;
        gnt0_d  = ~g;
        gnt1_d  = g;
        if (lock_g) begin
          // Pointer is left alone while locked; it is flipped on lock exit.
          state_d = g ? ST_LOCK1 : ST_LOCK0;
          cnt_d   = 3'd1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
          pri_d   = ~g;
        end
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      pri_q   <= 1'b0;
      cnt_q   <= 3'd0;
      q_q     <= '0;
      owner_q <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      owner_q <= owner_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
    end
  end

  assign Q      = q_q;
  assign GNT0   = gnt0_q;
  assign GNT1   = gnt1_q;
  assign OWNER  = owner_q;
  assign LOCKED = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dff_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dff_arbiter
//   Directed checks for dff_arbiter (N=16, MAX_BURST=4): reset, round-robin,
//   single request, locked burst with forced hand-off, early unlock, ENABLE
//   freeze during a burst, and asynchronous reset in the middle of a lock.
// -----------------------------------------------------------------------------
module tb_dff_arbiter;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic        REQ0, REQ1, LOCK0, LOCK1;
  logic [15:0] D0, D1;
  logic [15:0] Q;
  logic        GNT0, GNT1, OWNER, LOCKED;

  int total  = 0;
  int passed = 0;

  dff_arbiter #(.N(16), .MAX_BURST(4)) dut (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .ENABLE (ENABLE),
    .REQ0   (REQ0),
    .REQ1   (REQ1),
    .LOCK0  (LOCK0),
    .LOCK1  (LOCK1),
    .D0     (D0),
    .D1     (D1),
    .Q      (Q),
    .GNT0   (GNT0),
    .GNT1   (GNT1),
    .OWNER  (OWNER),
    .LOCKED (LOCKED)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  // Check the full visible state in one call.
  task automatic chk_all(input string tag, input logic [15:0] q, input logic g0,
                         input logic g1, input logic own, input logic lck);
    chk({tag, ".Q"},      {16'h0, Q},      {16'h0, q});
    chk({tag, ".GNT0"},   {31'h0, GNT0},   {31'h0, g0});
    chk({tag, ".GNT1"},   {31'h0, GNT1},   {31'h0, g1});
    chk({tag, ".OWNER"},  {31'h0, OWNER},  {31'h0, own});
    chk({tag, ".LOCKED"}, {31'h0, LOCKED}, {31'h0, lck});
  endtask

  initial begin
    RESET = 1'b0; ENABLE = 1'b0;
    REQ0 = 1'b0; REQ1 = 1'b0; LOCK0 = 1'b0; LOCK1 = 1'b0;
    D0 = 16'h0; D1 = 16'h0;
    #3;
    chk_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CLOCK);
    RESET = 1'b1;

    // Round-robin with both requesting, no lock
    ENABLE = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1; D0 = 16'h1111; D1 = 16'h2222;
    step(); chk_all("rr1", 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk_all("rr2", 16'h2222, 1'b0, 1'b1, 1'b1, 1'b0);
    step(); chk_all("rr3", 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk_all("rr4", 16'h2222, 1'b0, 1'b1, 1'b1, 1'b0);

    // Single request from 1; grant pulses for exactly one cycle
    REQ0 = 1'b0; REQ1 = 1'b1; D1 = 16'h8000;
    step(); chk_all("single1", 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0);
    REQ1 = 1'b0;
    step(); chk_all("single1_idle", 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);

    // Locked burst on 0 (PRI=0): four grants, then forced hand-off to 1
    REQ0 = 1'b1; REQ1 = 1'b1; LOCK0 = 1'b1; D0 = 16'hAAA0; D1 = 16'hBBBB;
    for (int i = 1; i <= 4; i++) begin
      D0 = 16'hAAA0 + 16'(i);
      step();
      chk_all("burst", 16'hAAA0 + 16'(i), 1'b1, 1'b0, 1'b0, 1'b1);
    end
    step(); chk_all("burst_handoff", 16'hBBBB, 1'b0, 1'b1, 1'b1, 1'b0);

    // Early unlock at CNT=2 with 1 waiting: 1 wins, PRI then points at 0
    REQ0 = 1'b1; REQ1 = 1'b0; LOCK0 = 1'b1; D0 = 16'h0C0C;
    step(); chk_all("unlk_c1", 16'h0C0C, 1'b1, 1'b0, 1'b0, 1'b1);
    step(); chk_all("unlk_c2", 16'h0C0C, 1'b1, 1'b0, 1'b0, 1'b1);
    LOCK0 = 1'b0; REQ1 = 1'b1; D1 = 16'h0D0D;
    step(); chk_all("unlk_g1", 16'h0D0D, 1'b0, 1'b1, 1'b1, 1'b0);
    D0 = 16'h0E0E;
    step(); chk_all("unlk_pri0", 16'h0E0E, 1'b1, 1'b0, 1'b0, 1'b0);

    // ENABLE freeze during a lock on 0 (PRI=1 now, only 0 requests)
    REQ0 = 1'b1; REQ1 = 1'b0; LOCK0 = 1'b1; D0 = 16'h5555;
    step(); chk_all("frz_c1", 16'h5555, 1'b1, 1'b0, 1'b0, 1'b1);
    step(); chk_all("frz_c2", 16'h5555, 1'b1, 1'b0, 1'b0, 1'b1);
    ENABLE = 1'b0; D0 = 16'h6666;
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("frz_hold", 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    ENABLE = 1'b1;
    step(); chk_all("frz_c3", 16'h6666, 1'b1, 1'b0, 1'b0, 1'b1);
    step(); chk_all("frz_c4", 16'h6666, 1'b1, 1'b0, 1'b0, 1'b1);
    // Burst exhausted and 1 not requesting: no grant, back to IDLE
    step(); chk_all("frz_exhaust", 16'h6666, 1'b0, 1'b0, 1'b0, 1'b0);

    // Async reset in the middle of a lock on 1 (PRI=1 after exhaustion)
    REQ0 = 1'b0; LOCK0 = 1'b0; REQ1 = 1'b1; LOCK1 = 1'b1; D1 = 16'h7777;
    step(); chk_all("rst_l1", 16'h7777, 1'b0, 1'b1, 1'b1, 1'b1);
    step(); chk_all("rst_l2", 16'h7777, 1'b0, 1'b1, 1'b1, 1'b1);
    #2 RESET = 1'b0;
    #1 chk_all("rst_async", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 RESET = 1'b1;
    REQ0 = 1'b1; REQ1 = 1'b1; LOCK1 = 1'b0; D0 = 16'h1234; D1 = 16'h4321;
    step(); chk_all("rst_first", 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk_all("rst_second", 16'h4321, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dff_arbiter.md
DFF_ARBITER -- requirements
Module: dff_arbiter

Interface
REQ-001 Parameter: N, default 16, data width of the shared register.
REQ-002 Parameter: MAX_BURST, default 4, maximum consecutive locked grants to one requester, range 1..7.
REQ-003 Port: CLOCK  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: RESET  input  1  asynchronous, active-low reset.
REQ-005 Port: ENABLE  input  1  global advance; 0 freezes all state.
REQ-006 Port: REQ0 / REQ1  input  1 each  write request from requester 0 / 1.
REQ-007 Port: LOCK0 / LOCK1  input  1 each  requester asks to keep ownership after its grant.
REQ-008 Port: D0 / D1  input  N each  write data from requester 0 / 1.
REQ-009 Port: Q  output  N  shared register contents.
REQ-010 Port: GNT0 / GNT1  output  1 each  registered one-cycle grant; high in the cycle after the edge that wrote that requester's data into Q.
REQ-011 Port: OWNER  output  1  index of the requester whose data is currently in Q.
REQ-012 Port: LOCKED  output  1  high while the FSM is in LOCK0 or LOCK1.

Function
REQ-013 FSM states SHALL be IDLE, LOCK0 and LOCK1, plus a 1-bit priority pointer PRI and a 3-bit burst counter CNT.
REQ-014 On every rising edge with ENABLE=0, Q, OWNER, state, PRI and CNT SHALL hold, and GNT0/GNT1 SHALL be driven to 0.
REQ-015 In IDLE with ENABLE=1 and exactly one REQx high, the block SHALL grant x.
REQ-016 In IDLE with both requests high, the block SHALL grant PRI.
REQ-017 In IDLE with no request high, Q SHALL hold and both GNTs SHALL be 0.
REQ-018 A grant to x at an edge SHALL set Q<=Dx, OWNER<=x, GNTx<=1 and the other GNT<=0; write latency is exactly one edge.
REQ-019 An unlocked grant to x SHALL set PRI<=~x (round-robin).
REQ-020 A grant from IDLE with LOCKx=1 SHALL move the FSM to LOCKx with CNT<=1; otherwise the FSM SHALL stay in IDLE with CNT<=0.
REQ-021 In LOCKx with REQx=1, LOCKx=1 and CNT<MAX_BURST, the block SHALL grant x (ignoring the other request) and set CNT<=CNT+1.
REQ-022 In LOCKx when REQx=0 or LOCKx=0, the FSM SHALL go to IDLE with PRI<=~x and CNT<=0.
- In that same edge it SHALL arbitrate both requests as in IDLE, using the updated PRI.
REQ-023 In LOCKx with CNT=MAX_BURST, the FSM SHALL go to IDLE with PRI<=~x and CNT<=0.
- In that same edge requester x SHALL be excluded, and the other requester SHALL be granted if it is requesting.
REQ-024 LOCKx SHALL be ignored on a requester that is not being granted.
REQ-025 At most one GNT SHALL be high in any cycle.

Reset
REQ-026 While RESET=0, asynchronously and regardless of CLOCK:
- Q=0, GNT0=GNT1=0, OWNER=0, LOCKED=0
- state=IDLE, PRI=0, CNT=0
REQ-027 Deasserting RESET mid-burst SHALL resume in IDLE with no partial grant; the first grant after reset deassertion SHALL obey REQ-015/016 with PRI=0.

Verification
REQ-028 Reset, ENABLE=1, REQ0=REQ1=1, D0=16'h1111, D1=16'h2222, no lock, 4 edges -> Q sequence 1111, 2222, 1111, 2222; GNTs alternate starting with GNT0.
REQ-029 REQ1=1 only, D1=16'h8000 -> Q=16'h8000 one edge later; GNT1 pulses for exactly one cycle; OWNER=1.
REQ-030 Both requesting, LOCK0=1 held, MAX_BURST=4 -> GNT0 for 4 consecutive cycles with LOCKED=1; then GNT1 on the 5th edge with LOCKED=0.
REQ-031 Locked on requester 0 at CNT=2, LOCK0 dropped, REQ1=1 -> next edge grants 1; PRI then 0.
REQ-032 ENABLE=0 for 3 cycles during a lock -> Q, CNT and LOCKED unchanged and GNTs 0; resumes the count on re-enable.
REQ-033 RESET pulsed low between edges during LOCK1 -> Q=0 and LOCKED=0 immediately; first grant after release goes to requester 0 when both request.
